// File: rtl/gemm_feeder.sv
// Purpose: buffers A/B matrices, replays them in gemm_array input order, then drains C results.
// Latency: first issue beat one cycle after the completing load handshake; results one register stage.
// Backpressure: s_*_ready low once a matrix is full or outside LOAD; array side and m_c have none.
module gemm_feeder #(
    parameter int C_DATA_WIDTH = 32,
    parameter int C_DIM        = 4,
    parameter int C_DRAIN_WAIT = 16
) (
    input  logic                    clock,
    input  logic                    i_reset_n,
    input  logic [C_DATA_WIDTH-1:0] s_a_data,
    input  logic                    s_a_valid,
    output logic                    s_a_ready,
    input  logic [C_DATA_WIDTH-1:0] s_b_data,
    input  logic                    s_b_valid,
    output logic                    s_b_ready,
    output logic [C_DATA_WIDTH-1:0] o_a_data,
    output logic [C_DATA_WIDTH-1:0] o_b_data,
    output logic                    o_in_valid,
    output logic                    o_rd_output,
    input  logic [C_DATA_WIDTH-1:0] i_c_data,
    input  logic                    i_c_valid,
    output logic [C_DATA_WIDTH-1:0] m_c_data,
    output logic                    m_c_valid,
    output logic                    o_busy,
    output logic                    o_done
);

    localparam int NN = C_DIM * C_DIM;
    localparam int NK = C_DIM * (C_DIM + 1);
    localparam int CW = $clog2(NN + 1);
    localparam int KW = $clog2(NK + 1);
    localparam int WW = $clog2(C_DRAIN_WAIT + 1);
    localparam int AW = $clog2(NN);

    localparam logic [CW-1:0] NN_C   = CW'(NN);
    localparam logic [CW-1:0] NN_M1  = CW'(NN - 1);
    localparam logic [KW-1:0] K_LAST = KW'(NK - 1);
    localparam logic [KW-1:0] K_N    = KW'(C_DIM);
    localparam logic [KW-1:0] K_NN   = KW'(NN);
    localparam logic [WW-1:0] W_LAST = WW'(C_DRAIN_WAIT - 1);

    typedef enum logic [1:0] {ST_LOAD, ST_ISSUE, ST_WAIT, ST_DRAIN} state_t;

    state_t                  state_q, state_d;
    logic                    run_q;
    logic [CW-1:0]           a_cnt, b_cnt, c_cnt;
    logic [KW-1:0]           k_cnt;
    logic [WW-1:0]           w_cnt;
    logic [C_DATA_WIDTH-1:0] buf_a [NN];
    logic [C_DATA_WIDTH-1:0] buf_b [NN];

    logic a_hs, b_hs, c_hs, a_full, b_full;

    // run_q keeps the load side closed until the first clock after reset release
    assign s_a_ready = run_q && (state_q == ST_LOAD) && (a_cnt < NN_C);
    assign s_b_ready = run_q && (state_q == ST_LOAD) && (b_cnt < NN_C);
    assign a_hs      = s_a_valid && s_a_ready;
    assign b_hs      = s_b_valid && s_b_ready;
    assign c_hs      = (state_q == ST_DRAIN) && i_c_valid;
    // A matrix counts as complete including the handshake happening this cycle
    assign a_full    = (a_cnt == NN_C) || (a_hs && (a_cnt == NN_M1));
    assign b_full    = (b_cnt == NN_C) || (b_hs && (b_cnt == NN_M1));

    assign o_busy      = (state_q != ST_LOAD);
    assign o_rd_output = (state_q == ST_DRAIN);

    // State register
    always_ff @(posedge clock or negedge i_reset_n) begin
        if (!i_reset_n) state_q <= ST_LOAD;
        else            state_q <= state_d;
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD:  if (a_full && b_full) state_d = ST_ISSUE;
            ST_ISSUE: if (k_cnt == K_LAST) state_d = ST_WAIT;
            ST_WAIT:  if (w_cnt == W_LAST) state_d = ST_DRAIN;
            ST_DRAIN: if (c_hs && (c_cnt == NN_M1)) state_d = ST_LOAD;
            default:  state_d = ST_LOAD;
        endcase
    end

    // Load, issue, wait and drain counters; load counts clear on leaving LOAD
    always_ff @(posedge clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            run_q <= 1'b0;
            a_cnt <= '0;
            b_cnt <= '0;
            c_cnt <= '0;
            k_cnt <= '0;
            w_cnt <= '0;
        end else begin
            run_q <= 1'b1;
            if (state_q == ST_LOAD && state_d == ST_ISSUE) begin
                a_cnt <= '0;
                b_cnt <= '0;
            end else begin
                if (a_hs) a_cnt <= a_cnt + 1'b1;
                if (b_hs) b_cnt <= b_cnt + 1'b1;
            end
            k_cnt <= (state_q == ST_ISSUE) ? k_cnt + 1'b1 : '0;
            w_cnt <= (state_q == ST_WAIT)  ? w_cnt + 1'b1 : '0;
            if (c_hs) c_cnt <= (c_cnt == NN_M1) ? '0 : c_cnt + 1'b1;
        end
    end

    // Matrix buffers; contents survive reset
    always_ff @(posedge clock) begin
        if (a_hs) buf_a[AW'(a_cnt)] <= s_a_data;
        if (b_hs) buf_b[AW'(b_cnt)] <= s_b_data;
    end

    // Result register stage and completion pulse
    always_ff @(posedge clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            m_c_valid <= 1'b0;
            m_c_data  <= '0;
            o_done    <= 1'b0;
        end else begin
            m_c_valid <= c_hs;
            if (c_hs) m_c_data <= i_c_data;
            o_done    <= c_hs && (c_cnt == NN_M1);
        end
    end

    // Skewed issue schedule: A lags B by one row, zero-padded at both ends
    always_comb begin
        o_in_valid = 1'b0;
        o_a_data   = '0;
        o_b_data   = '0;
        if (state_q == ST_ISSUE) begin
            o_in_valid = 1'b1;
            if (k_cnt >= K_N)  o_a_data = buf_a[AW'(k_cnt - K_N)];
            if (k_cnt <  K_NN) o_b_data = buf_b[AW'(k_cnt)];
        end
    end

endmodule

// File: tb/tb_gemm_feeder.sv
// Purpose: directed bench for gemm_feeder with N=4, drain wait 16, acting as source and stub array.
// Latency: inputs driven and outputs sampled 1ns after each rising clock edge.
// Backpressure: load streams honour s_*_ready; the stub array returns results with fixed gaps.
module tb_gemm_feeder;

    logic        clock = 1'b0;
    logic        i_reset_n;
    logic [31:0] s_a_data, s_b_data, o_a_data, o_b_data, i_c_data, m_c_data;
    logic        s_a_valid, s_a_ready, s_b_valid, s_b_ready;
    logic        o_in_valid, o_rd_output, i_c_valid, m_c_valid, o_busy, o_done;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] a_mat [16];
    logic [31:0] b_mat [16];
    logic [31:0] c_vals [16];

    gemm_feeder #(.C_DATA_WIDTH(32), .C_DIM(4), .C_DRAIN_WAIT(16)) dut (
        .clock(clock), .i_reset_n(i_reset_n),
        .s_a_data(s_a_data), .s_a_valid(s_a_valid), .s_a_ready(s_a_ready),
        .s_b_data(s_b_data), .s_b_valid(s_b_valid), .s_b_ready(s_b_ready),
        .o_a_data(o_a_data), .o_b_data(o_b_data), .o_in_valid(o_in_valid),
        .o_rd_output(o_rd_output), .i_c_data(i_c_data), .i_c_valid(i_c_valid),
        .m_c_data(m_c_data), .m_c_valid(m_c_valid), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic bit gap_ok(input int mode, input int cyc);
        case (mode)
            0:       return 1'b1;
            1:       return (cyc % 3) != 1;
            default: return (cyc % 5) < 3;
        endcase
    endfunction

    // Stream A and B concurrently; returns at the first cycle after the last handshake
    task automatic load_job(input int amode, input int bmode, input int b_start);
        int  ai = 0, bi = 0, cyc = 0;
        bit  a_take, b_take, seen = 1'b0;
        while ((ai < 16 || bi < 16) && cyc < 400) begin
            if (ai == 16 && bi == 0 && !seen) begin
                chk("ready_a_full_b_open", {s_a_ready, s_b_ready}, 2'b01);
                seen = 1'b1;
            end
            s_a_valid = (ai < 16) && gap_ok(amode, cyc);
            s_a_data  = (ai < 16) ? a_mat[ai] : 32'h0;
            s_b_valid = (bi < 16) && (cyc >= b_start) && gap_ok(bmode, cyc);
            s_b_data  = (bi < 16) ? b_mat[bi] : 32'h0;
            a_take = s_a_valid && s_a_ready;
            b_take = s_b_valid && s_b_ready;
            tick();
            if (a_take) ai++;
            if (b_take) bi++;
            cyc++;
        end
        s_a_valid = 1'b0;
        s_b_valid = 1'b0;
        chk("load_counts", {ai, bi}, {32'd16, 32'd16});
    endtask

    // Check issue beats 0..nbeats-1 starting at the current cycle
    task automatic check_issue(input int nbeats);
        logic [31:0] ea, eb;
        for (int k = 0; k < nbeats; k++) begin
            ea = (k < 4)  ? a_mat[k-4 < 0 ? 0 : k-4] : 32'h0;
            ea = (k < 4)  ? 32'h0 : a_mat[k-4];
            eb = (k < 16) ? b_mat[k] : 32'h0;
            chk($sformatf("issue_beat%0d", k), {o_in_valid, o_busy, o_a_data, o_b_data},
                {1'b1, 1'b1, ea, eb});
            tick();
        end
    endtask

    // WAIT phase: pulse i_c_valid, expect no results and exactly 16 quiet cycles
    task automatic check_wait();
        int cnt = 0;
        while (!o_rd_output && cnt < 100) begin
            chk("wait_quiet", {o_in_valid, m_c_valid, o_busy}, 3'b001);
            i_c_valid = cnt[0];
            i_c_data  = 32'hDEAD_0000 + cnt;
            tick();
            cnt++;
        end
        i_c_valid = 1'b0;
        chk("wait_cycles", cnt, 16);
        chk("drain_entry_no_result", m_c_valid, 1'b0);
    endtask

    // DRAIN phase with the stub array returning a beat every 'gap' cycles
    task automatic drain(input int gap, input int job);
        int sent = 0, got = 0, cyc = 0, dones = 0;
        for (int i = 0; i < 16; i++) c_vals[i] = 32'hC000_0000 + job * 256 + i;
        while (got < 16 && cyc < 300) begin
            if (o_done) dones++;
            if (m_c_valid) begin
                chk($sformatf("c_beat%0d", got), m_c_data, c_vals[got]);
                if (got == 15) begin
                    chk("last_beat_done_rd_ready", {o_done, o_rd_output, s_a_ready, o_busy}, 4'b1010);
                end
                got++;
            end
            if (o_rd_output && sent < 16 && (cyc % gap) == 0) begin
                i_c_valid = 1'b1;
                i_c_data  = c_vals[sent];
                sent++;
            end else begin
                i_c_valid = 1'b0;
            end
            tick();
            cyc++;
        end
        i_c_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (o_done) dones++;
            if (i == 0) chk("post_drain_idle", {m_c_valid, o_rd_output, o_in_valid}, 3'b000);
            tick();
        end
        chk("done_pulses", dones, 1);
    endtask

    task automatic set_mats(input logic [31:0] abase, input logic [31:0] bbase, input bit ident);
        for (int i = 0; i < 16; i++) begin
            a_mat[i] = ident ? ((i % 5 == 0) ? 32'd1 : 32'd0) : abase + i * 3;
            b_mat[i] = bbase + i;
        end
    endtask

    initial begin
        i_reset_n = 1'b0;
        s_a_valid = 1'b0; s_a_data = '0;
        s_b_valid = 1'b0; s_b_data = '0;
        i_c_valid = 1'b0; i_c_data = '0;
        #12;
        chk("reset_ctrl", {s_a_ready, s_b_ready, o_in_valid, o_rd_output, m_c_valid, o_busy, o_done}, 7'd0);
        chk("reset_data", {o_a_data, o_b_data, m_c_data}, 96'd0);
        tick();
        i_reset_n = 1'b1;
        tick();

        // Job 1: identity A, B=1..16, no gaps
        set_mats(32'h0, 32'd1, 1'b1);
        load_job(0, 0, 0);
        check_issue(20);
        check_wait();
        drain(1, 1);

        // Job 2: A first, 7 idle cycles, then B; results every 3rd cycle
        set_mats(32'hA000_0000, 32'hB000_0100, 1'b0);
        load_job(0, 0, 23);
        check_issue(20);
        check_wait();
        drain(3, 2);

        // Job 3: same matrices with different gap patterns per stream
        load_job(1, 2, 0);
        check_issue(20);
        check_wait();
        drain(2, 3);

        // Job 4: reset during issue beat 9
        set_mats(32'h1111_0000, 32'h2222_0000, 1'b0);
        load_job(2, 1, 0);
        check_issue(9);
        i_reset_n = 1'b0;
        #1;
        chk("midreset_ctrl", {s_a_ready, s_b_ready, o_in_valid, o_rd_output, m_c_valid, o_busy, o_done}, 7'd0);
        chk("midreset_data", {o_a_data, o_b_data, m_c_data}, 96'd0);
        tick();
        i_reset_n = 1'b1;
        tick();

        // Job 5: fresh job after reset
        set_mats(32'h3333_0000, 32'h4444_0000, 1'b0);
        load_job(0, 1, 0);
        check_issue(20);
        check_wait();
        drain(1, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
